dq_window_sampler: RTL and testbench

DQ_WINDOW_SAMPLER -- requirements
Module: dq_window_sampler

---
 rtl/sampler_pkg.sv | 10 +
 rtl/sampler_hist_ring.sv | 39 +++
 rtl/dq_window_sampler.sv | 109 ++++++++++
 tb/tb_dq_window_sampler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// Shared constants for the DQ window sampler: sample direction codes and
// default bus width / history depth.
package sampler_pkg;

  localparam logic DIR_BACK   = 1'b0;
  localparam logic DIR_FRONT  = 1'b1;
  localparam int   DEF_DATA_W = 8;
  localparam int   DEF_DEPTH  = 32;

endpackage

// File: rtl/sampler_hist_ring.sv
// History ring for the DQ window sampler: one write per cycle at wr_ptr and
// one registered read port that holds its value while rd_en is low.
module sampler_hist_ring
  import sampler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int OFS_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W:0]   wr_data,
  input  logic              rd_en,
  input  logic [OFS_W-1:0]  rd_ofs,
  input  logic              rd_byp,
  input  logic [DATA_W:0]   byp_data,
  output logic [DATA_W:0]   rd_data
);

  logic [DATA_W:0]  mem [DEPTH];
  logic [OFS_W-1:0] wr_ptr;
  logic [OFS_W-1:0] rd_addr;

  // Offset counts back from the entry being written this cycle.
  assign rd_addr = wr_ptr - rd_ofs;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr  <= '0;
      rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + OFS_W'(1);
      if (rd_en) rd_data <= rd_byp ? byp_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/dq_window_sampler.sv
// Samples the DQ bus at a cycle offset backward (history) or forward (future)
// from a strobe. Optional saturating statistics counters: SAMPLER_STATS_EN.
module dq_window_sampler
  import sampler_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int OFS_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DQ_OUT,
  input  logic              DQ_OUT_VALID,
  input  logic              STRB,
  input  logic              STRB_DIR,
  input  logic [OFS_W-1:0]  STRB_OFS,
  output logic [DATA_W-1:0] SMP_DATA,
  output logic              SMP_STB,
  output logic              SMP_DQ_VALID,
  output logic              COLLIDE
`ifdef SAMPLER_STATS_EN
  ,
  output logic [15:0]       STAT_SMP,
  output logic [15:0]       STAT_COLL
`endif
);

  logic [DEPTH-2:0] pend_q;
  logic [DEPTH-2:0] pend_set;
  logic [DEPTH-1:0] pend_ext;
  logic [OFS_W-1:0] fill_q;
  logic             stb_q;
  logic             due;
  logic             k_zero;
  logic             fwd_new;
  logic             now_req;
  logic             no_hist;
  logic             smp_req;
  logic             rd_byp;
  logic [DATA_W:0]  cur_data;
  logic [DATA_W:0]  byp_data;
  logic [DATA_W:0]  rd_data;

  // pend_q[j] marks a forward sample due j cycles from now; bit 0 is due now.
  assign pend_ext = {1'b0, pend_q};
  assign due      = pend_q[0];
  assign k_zero   = (STRB_OFS == '0);
  assign fwd_new  = STRB && (STRB_DIR == DIR_FRONT) && !k_zero;
  assign now_req  = STRB && !fwd_new;
  assign no_hist  = (STRB_OFS > fill_q);
  assign smp_req  = due || now_req;
  assign cur_data = {DQ_OUT, DQ_OUT_VALID};

  // A due forward sample always wins over an immediate request in the same cycle.
  assign rd_byp   = due || k_zero || no_hist;
  assign byp_data = (due || k_zero) ? cur_data : '0;

  // Flags the request cycle itself, so it is combinational from STRB.
  assign COLLIDE  = (fwd_new && pend_ext[STRB_OFS]) || (now_req && due);

  always_comb begin
    pend_set = '0;
    if (fwd_new) pend_set[STRB_OFS - OFS_W'(1)] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q <= '0;
      fill_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      pend_q <= (pend_q >> 1) | pend_set;
      stb_q  <= smp_req;
      if (fill_q != OFS_W'(DEPTH - 1)) fill_q <= fill_q + OFS_W'(1);
    end
  end

  sampler_hist_ring #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .OFS_W  (OFS_W)
  ) u_ring (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .wr_data  (cur_data),
    .rd_en    (smp_req),
    .rd_ofs   (STRB_OFS),
    .rd_byp   (rd_byp),
    .byp_data (byp_data),
    .rd_data  (rd_data)
  );

  assign SMP_STB      = stb_q;
  assign SMP_DATA     = rd_data[DATA_W:1];
  assign SMP_DQ_VALID = rd_data[0];

`ifdef SAMPLER_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STAT_SMP  <= '0;
      STAT_COLL <= '0;
    end else begin
      if (stb_q && (STAT_SMP != 16'hFFFF))    STAT_SMP  <= STAT_SMP + 16'd1;
      if (COLLIDE && (STAT_COLL != 16'hFFFF)) STAT_COLL <= STAT_COLL + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dq_window_sampler.sv
// Scoreboard bench for dq_window_sampler: directed strobes push expected
// samples/collisions; a negedge monitor matches them against the outputs.
module tb_dq_window_sampler;

  logic       CLK;
  logic       RST_N;
  logic [7:0] DQ_OUT;
  logic       DQ_OUT_VALID;
  logic       STRB;
  logic       STRB_DIR;
  logic [4:0] STRB_OFS;
  logic [7:0] SMP_DATA;
  logic       SMP_STB;
  logic       SMP_DQ_VALID;
  logic       COLLIDE;
`ifdef SAMPLER_STATS_EN
  logic [15:0] STAT_SMP;
  logic [15:0] STAT_COLL;
`endif

  dq_window_sampler dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .DQ_OUT       (DQ_OUT),
    .DQ_OUT_VALID (DQ_OUT_VALID),
    .STRB         (STRB),
    .STRB_DIR     (STRB_DIR),
    .STRB_OFS     (STRB_OFS),
    .SMP_DATA     (SMP_DATA),
    .SMP_STB      (SMP_STB),
    .SMP_DQ_VALID (SMP_DQ_VALID),
    .COLLIDE      (COLLIDE)
`ifdef SAMPLER_STATS_EN
    ,
    .STAT_SMP     (STAT_SMP),
    .STAT_COLL    (STAT_COLL)
`endif
  );

  typedef struct {
    int   ph;
    int   cyc;
    logic dir;
    int   k;
    bit   has_stb;
    int   stb_cyc;
    int   data;
    logic vld;
    bit   coll;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       vld;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_smp[$];
  int   exp_coll[$];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         mon_idx;
  logic [7:0] hold_d  = 8'd0;
  logic       hold_v  = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic add_vec(input int ph, input int c, input logic d, input int k,
                         input bit hs, input int sc, input int dat, input logic v,
                         input bit co);
    vec_t t;
    t.ph = ph; t.cyc = c; t.dir = d; t.k = k; t.has_stb = hs;
    t.stb_cyc = sc; t.data = dat; t.vld = v; t.coll = co;
    vecs.push_back(t);
  endtask

  task automatic apply(input int ph);
    exp_t e;
    STRB     = 1'b0;
    STRB_DIR = 1'($urandom_range(0, 1));
    STRB_OFS = 5'($urandom_range(0, 31));
    foreach (vecs[i]) begin
      if (vecs[i].ph == ph && vecs[i].cyc == cyc) begin
        STRB     = 1'b1;
        STRB_DIR = vecs[i].dir;
        STRB_OFS = 5'(vecs[i].k);
        if (vecs[i].has_stb) begin
          e.cyc  = vecs[i].stb_cyc;
          e.data = 8'(vecs[i].data);
          e.vld  = vecs[i].vld;
          exp_smp.push_back(e);
        end
        if (vecs[i].coll) exp_coll.push_back(cyc);
      end
    end
  endtask

  task automatic next_cycle(input int ph);
    @(posedge CLK);
    #1;
    cyc++;
    DQ_OUT       = 8'(cyc);
    DQ_OUT_VALID = (cyc != 80);
    apply(ph);
  endtask

  always @(negedge CLK) begin
    if (!RST_N) begin
      hold_d = 8'd0;
      hold_v = 1'b0;
      n_tests++;
      if (SMP_STB !== 1'b0 || COLLIDE !== 1'b0 || SMP_DATA !== 8'd0 || SMP_DQ_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: stb=%b coll=%b data=%0d vld=%b, required all 0",
                 SMP_STB, COLLIDE, SMP_DATA, SMP_DQ_VALID);
      end
    end else begin
      if (SMP_STB === 1'b1) begin
        mon_idx = -1;
        foreach (exp_smp[i]) if (mon_idx < 0 && exp_smp[i].cyc == cyc) mon_idx = i;
        n_tests++;
        if (mon_idx < 0) begin
          n_fail++;
          $display("FAIL unexpected_stb: SMP_STB=1 at cycle %0d data=%0d, required no pulse",
                   cyc, SMP_DATA);
        end else begin
          if (SMP_DATA !== exp_smp[mon_idx].data || SMP_DQ_VALID !== exp_smp[mon_idx].vld) begin
            n_fail++;
            $display("FAIL sample_c%0d: data=%0d vld=%b, required data=%0d vld=%b",
                     cyc, SMP_DATA, SMP_DQ_VALID, exp_smp[mon_idx].data, exp_smp[mon_idx].vld);
          end
          hold_d = exp_smp[mon_idx].data;
          hold_v = exp_smp[mon_idx].vld;
          exp_smp.delete(mon_idx);
        end
      end else begin
        n_tests++;
        if (SMP_STB !== 1'b0 || SMP_DATA !== hold_d || SMP_DQ_VALID !== hold_v) begin
          n_fail++;
          $display("FAIL hold_c%0d: stb=%b data=%0d vld=%b, required stb=0 data=%0d vld=%b",
                   cyc, SMP_STB, SMP_DATA, SMP_DQ_VALID, hold_d, hold_v);
        end
      end
      if (COLLIDE !== 1'b0) begin
        mon_idx = -1;
        foreach (exp_coll[i]) if (mon_idx < 0 && exp_coll[i] == cyc) mon_idx = i;
        n_tests++;
        if (mon_idx < 0) begin
          n_fail++;
          $display("FAIL unexpected_collide: COLLIDE=%b at cycle %0d, required 0", COLLIDE, cyc);
        end else begin
          exp_coll.delete(mon_idx);
        end
      end
    end
  end

  initial begin
    // phase, cycle, dir, k, has_stb, stb_cycle, data, valid, collide
    add_vec(0,   3, 1'b0, 10, 1,   4,   0, 1'b0, 0);
    add_vec(0,   8, 1'b0,  2, 1,   9,   6, 1'b1, 0);
    add_vec(0,  40, 1'b0,  5, 1,  41,  35, 1'b1, 0);
    add_vec(0,  45, 1'b0,  0, 1,  46,  45, 1'b1, 0);
    add_vec(0,  47, 1'b1,  0, 1,  48,  47, 1'b1, 0);
    add_vec(0,  50, 1'b1,  3, 1,  54,  53, 1'b1, 0);
    add_vec(0,  51, 1'b1,  3, 1,  55,  54, 1'b1, 0);
    add_vec(0,  52, 1'b1,  3, 1,  56,  55, 1'b1, 0);
    add_vec(0,  60, 1'b1,  4, 1,  65,  64, 1'b1, 0);
    add_vec(0,  61, 1'b1,  3, 0,   0,   0, 1'b0, 1);
    add_vec(0,  70, 1'b1,  2, 1,  73,  72, 1'b1, 0);
    add_vec(0,  72, 1'b0,  1, 0,   0,   0, 1'b0, 1);
    add_vec(0,  82, 1'b0,  2, 1,  83,  80, 1'b0, 0);
    add_vec(0,  90, 1'b0, 31, 1,  91,  59, 1'b1, 0);
    add_vec(0, 100, 1'b1, 31, 1, 132, 131, 1'b1, 0);
    add_vec(0, 120, 1'b1,  1, 1, 122, 121, 1'b1, 0);
    add_vec(0, 121, 1'b1,  0, 0,   0,   0, 1'b0, 1);
    add_vec(0, 140, 1'b1, 20, 0,   0,   0, 1'b0, 0);
    add_vec(1,   5, 1'b0,  8, 1,   6,   0, 1'b0, 0);
    add_vec(1,  12, 1'b0,  3, 1,  13,   9, 1'b1, 0);

    RST_N        = 1'b1;
    DQ_OUT       = 8'd0;
    DQ_OUT_VALID = 1'b1;
    STRB         = 1'b0;
    STRB_DIR     = 1'b0;
    STRB_OFS     = 5'd0;
    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc   = 0;
    apply(0);
    while (cyc < 144) next_cycle(0);

    // Reset mid-run with the k=20 forward sample still pending.
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    STRB  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N        = 1'b1;
    cyc          = 0;
    DQ_OUT       = 8'd0;
    DQ_OUT_VALID = 1'b1;
    apply(1);
    while (cyc < 40) next_cycle(1);
    @(posedge CLK);
    #1;

    foreach (exp_smp[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_stb: no SMP_STB seen, required pulse at cycle %0d data=%0d",
               exp_smp[i].cyc, exp_smp[i].data);
    end
    foreach (exp_coll[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_collide: COLLIDE stayed 0, required pulse at cycle %0d", exp_coll[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
